// File: rtl/irq_pkg.sv
// irq_controller shared types and register map.
// Offsets are byte offsets inside the 32-byte block.
package irq_pkg;

  localparam int ID_W = 5;

  localparam logic [4:0] IRQ_PENDING     = 5'h00;
  localparam logic [4:0] IRQ_ENABLE      = 5'h04;
  localparam logic [4:0] IRQ_CLAIM       = 5'h08;
  localparam logic [4:0] IRQ_MTIME_LO    = 5'h0C;
  localparam logic [4:0] IRQ_MTIME_HI    = 5'h10;
  localparam logic [4:0] IRQ_MTIMECMP_LO = 5'h14;
  localparam logic [4:0] IRQ_MTIMECMP_HI = 5'h18;
  localparam logic [4:0] IRQ_CTRL        = 5'h1C;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } claim_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// 2-FF synchroniser for one async interrupt line,
// followed by a rising-edge pulse detector.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/irq_controller.sv
// Machine interrupt controller: pending/enable, priority
// claim/complete FSM, 64-bit mtime/mtimecmp timer.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            mem_en,
  input  logic            mem_we,
  input  logic [4:0]      mem_addr,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  output logic            interrupt
);

  logic [NSRC-1:0] edge_p;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] pend_en;
  logic [NSRC-1:0] clr;
  logic [ID_W-1:0] best_id;
  logic [ID_W-1:0] in_service;
  claim_state_t    state;
  logic            gie;
  logic            tie;
  logic [63:0]     mtime;
  logic [63:0]     mtime_nx;
  logic [63:0]     mtimecmp;
  logic            timer_hit;
  logic            rd;
  logic            wr;
  logic [4:0]      addr;
  logic            claim_go;
  logic [31:0]     pend_word;
  logic [31:0]     en_word;
  logic [31:0]     rdata_nx;
  logic            unused_ok;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_src[k]),
      .pulse(edge_p[k])
    );
  end

  assign addr      = {mem_addr[4:2], 2'b00};
  assign rd        = mem_en & ~mem_we;
  assign wr        = mem_en & mem_we;
  assign pend_en   = pending & enable;
  assign timer_hit = tie & (mtime >= mtimecmp);
  assign unused_ok = &{1'b0, mem_addr[1:0], mem_wdata};

  always_comb begin
    best_id = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (pend_en[k]) best_id = ID_W'(k + 1);
    end
  end

  assign claim_go = rd && (addr == IRQ_CLAIM) &&
                    (state == IDLE) && (best_id != '0);

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      clr[k] = claim_go && (best_id == ID_W'(k + 1));
    end
  end

  // An explicit write to either half overrides the increment.
  always_comb begin
    mtime_nx = mtime + 64'd1;
    if (wr && addr == IRQ_MTIME_LO) mtime_nx[31:0]  = mem_wdata;
    if (wr && addr == IRQ_MTIME_HI) mtime_nx[63:32] = mem_wdata;
  end

  always_comb begin
    pend_word = '0;
    pend_word[NSRC-1:0] = pending;
    pend_word[31] = timer_hit;
    en_word = '0;
    en_word[NSRC-1:0] = enable;
    rdata_nx = '0;
    case (addr)
      IRQ_PENDING:     rdata_nx = pend_word;
      IRQ_ENABLE:      rdata_nx = en_word;
      IRQ_CLAIM:       rdata_nx = claim_go ? 32'(best_id) : 32'd0;
      IRQ_MTIME_LO:    rdata_nx = mtime[31:0];
      IRQ_MTIME_HI:    rdata_nx = mtime[63:32];
      IRQ_MTIMECMP_LO: rdata_nx = mtimecmp[31:0];
      IRQ_MTIMECMP_HI: rdata_nx = mtimecmp[63:32];
      IRQ_CTRL:        rdata_nx = {30'd0, tie, gie};
      default:         rdata_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      enable     <= '0;
      gie        <= 1'b0;
      tie        <= 1'b0;
      mtime      <= '0;
      mtimecmp   <= '1;
      in_service <= '0;
      state      <= IDLE;
      mem_rdata  <= '0;
      interrupt  <= 1'b0;
    end else begin
      // A new edge beats a same-cycle claim clear.
      pending <= (pending & ~clr) | edge_p;
      mtime   <= mtime_nx;
      if (wr && addr == IRQ_ENABLE) enable <= mem_wdata[NSRC-1:0];
      if (wr && addr == IRQ_CTRL) {tie, gie} <= mem_wdata[1:0];
      if (wr && addr == IRQ_MTIMECMP_LO) mtimecmp[31:0] <= mem_wdata;
      if (wr && addr == IRQ_MTIMECMP_HI) mtimecmp[63:32] <= mem_wdata;
      unique case (state)
        IDLE: begin
          if (claim_go) begin
            in_service <= best_id;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (wr && addr == IRQ_CLAIM &&
              mem_wdata[ID_W-1:0] == in_service) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (rd) mem_rdata <= rdata_nx;
      interrupt <= gie & (((best_id != '0) && (state == IDLE)) |
                          timer_hit);
    end
  end

endmodule
